// File: rtl/key_event_gen.sv
// Turns debounced key levels into one-hot key events with typematic auto-repeat.
// Events are queued as per-key pending bits and presented by fixed priority over valid/yumi.
module key_event_fsm #(
    parameter int CW          = 4,
    parameter int DELAY       = 10,
    parameter int RATE        = 3,
    parameter bit REPEAT_EN   = 1'b1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic tick_i,
    input  logic key_i,
    input  logic clr_i,
    output logic pend_o
);
    typedef enum logic [1:0] {IDLE, DLY, RPT, HELD} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            pend_q, pend_d;
    logic            set;

    always_comb begin
        set = 1'b0;
        if (tick_i && key_i) begin
            unique case (state_q)
                IDLE:    set = 1'b1;
                DLY:     set = (cnt_q == CW'(DELAY - 1));
                RPT:     set = (cnt_q == CW'(RATE - 1));
                default: set = 1'b0;
            endcase
        end
    end

    // A new event wins over a same-cycle accept, so the fresh event stays queued.
    assign pend_d = set | (pend_q & ~clr_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (tick_i) begin
                unique case (state_q)
                    IDLE: if (key_i) begin
                        state_q <= REPEAT_EN ? DLY : HELD;
                        cnt_q   <= '0;
                    end
                    DLY: begin
                        if (!key_i) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CW'(DELAY - 1)) begin
                            state_q <= RPT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    RPT: begin
                        if (!key_i) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CW'(RATE - 1)) begin
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    HELD: if (!key_i) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pend_o = pend_q;
endmodule

module key_event_gen #(
    parameter int                 width_p        = 4,
    parameter int                 repeat_delay_p = 10,
    parameter int                 repeat_rate_p  = 3,
    parameter logic [width_p-1:0] repeat_mask_p  = {width_p{1'b1}}
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               tick_i,
    input  logic [width_p-1:0] keys_i,
    output logic               v_o,
    output logic [width_p-1:0] key_o,
    input  logic               yumi_i
);
    localparam int MAXV = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p : repeat_rate_p;
    localparam int CW   = $clog2(MAXV + 1);

    logic [width_p-1:0] pend;
    logic [width_p-1:0] clr;

    for (genvar k = 0; k < width_p; k++) begin : g_key
        key_event_fsm #(
            .CW        (CW),
            .DELAY     (repeat_delay_p),
            .RATE      (repeat_rate_p),
            .REPEAT_EN (repeat_mask_p[k])
        ) u_key (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .tick_i    (tick_i),
            .key_i     (keys_i[k]),
            .clr_i     (clr[k]),
            .pend_o    (pend[k])
        );
    end

    // Isolate the lowest set pending bit; key_o is zero when nothing is pending.
    assign key_o = pend & (~pend + width_p'(1));
    assign v_o   = |pend;
    assign clr   = key_o & {width_p{yumi_i}};
endmodule

// File: tb/tb_key_event_gen.sv
// Directed scenarios plus random holds, checked against a tick-count model of typematic events.
module tb_key_event_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] keys;
    logic       yumi_a, yumi_b;
    logic       v_a, v_b;
    logic [3:0] key_a, key_b;

    int n_chk = 0;
    int n_err = 0;

    // Instance A: D=10, R=3, key 2 does not repeat. Instance B: D=1, R=1, all repeat.
    key_event_gen #(.width_p(4), .repeat_delay_p(10), .repeat_rate_p(3), .repeat_mask_p(4'b1011)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .tick_i(tick), .keys_i(keys),
        .v_o(v_a), .key_o(key_a), .yumi_i(yumi_a));
    key_event_gen #(.width_p(4), .repeat_delay_p(1), .repeat_rate_p(1), .repeat_mask_p(4'b1111)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .tick_i(tick), .keys_i(keys),
        .v_o(v_b), .key_o(key_b), .yumi_i(yumi_b));

    always #5 clk = ~clk;

    int         held [2][4];
    logic [3:0] pend [2];
    int         dm [2] = '{10, 1};
    int         rm [2] = '{3, 1};
    logic [3:0] mm [2] = '{4'b1011, 4'b1111};
    int         cnt_a [4];

    function automatic logic [3:0] lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 4'b0000;
            for (int k = 0; k < 4; k++) held[i][k] = -1;
        end
    endtask

    // Key held for n ticks since its press yields events at n = 0, D, D+R, D+2R, ...
    task automatic mstep(input int i, input logic y);
        logic [3:0] ev, clr;
        ev = 4'b0000;
        if (tick) begin
            for (int k = 0; k < 4; k++) begin
                if (keys[k]) begin
                    held[i][k]++;
                    if (held[i][k] == 0 ||
                        (mm[i][k] && held[i][k] >= dm[i] && (held[i][k] - dm[i]) % rm[i] == 0))
                        ev[k] = 1'b1;
                end else begin
                    held[i][k] = -1;
                end
            end
        end
        clr = y ? lowest(pend[i]) : 4'b0000;
        pend[i] = (pend[i] & ~clr) | ev;
    endtask

    task automatic step(input logic [3:0] k, input logic t, input logic ya, input logic yb);
        keys = k; tick = t; yumi_a = ya; yumi_b = yb;
        @(posedge clk);
        mstep(0, ya);
        mstep(1, yb);
        #1;
        chk("v_a",   int'(v_a),   int'(|pend[0]));
        chk("key_a", int'(key_a), int'(lowest(pend[0])));
        chk("v_b",   int'(v_b),   int'(|pend[1]));
        chk("key_b", int'(key_b), int'(lowest(pend[1])));
        for (int j = 0; j < 4; j++) if (v_a && key_a[j]) cnt_a[j]++;
    endtask

    task automatic clr_cnt();
        for (int j = 0; j < 4; j++) cnt_a[j] = 0;
    endtask

    initial begin
        logic [3:0] kr;
        rst_n = 1'b0; keys = 4'b0; tick = 1'b0; yumi_a = 1'b0; yumi_b = 1'b0;
        mreset();
        clr_cnt();
        #1;
        chk("rst_v_a", int'(v_a), 0);
        chk("rst_key_a", int'(key_a), 0);
        chk("rst_v_b", int'(v_b), 0);
        #10 rst_n = 1'b1;

        // Key 0 held ticks 0..19 with yumi tied high: events at 0,10,13,16,19.
        for (int i = 0; i < 20; i++) step(4'b0001, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)  step(4'b0000, 1'b1, 1'b1, 1'b1);
        chk("s1_events", cnt_a[0], 5);

        // Non-repeating key 2: one event per press.
        clr_cnt();
        for (int i = 0; i < 30; i++) step(4'b0100, 1'b1, 1'b1, 1'b1);
        chk("s2_first", cnt_a[2], 1);
        for (int i = 0; i < 2; i++) step(4'b0000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, 1'b1, 1'b1);
        chk("s2_second", cnt_a[2], 2);
        for (int i = 0; i < 2; i++) step(4'b0000, 1'b1, 1'b1, 1'b1);

        // Keys 1 and 3 together, consumer stalled, then drained in priority order.
        step(4'b1010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b1010, 1'b0, 1'b0, 1'b0);
            chk("s3_hold_key", int'(key_a), 4'b0010);
        end
        step(4'b1010, 1'b0, 1'b1, 1'b0);
        chk("s3_next_key", int'(key_a), 4'b1000);
        step(4'b1010, 1'b0, 1'b1, 1'b0);
        chk("s3_drained", int'(v_a), 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b1, 1'b1);

        // D=R=1 instance: events coalesce; accept on an event tick keeps v_o high.
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b1, 1'b1, 1'b0);
        chk("s4_coalesce_v", int'(v_b), 1);
        chk("s4_coalesce_key", int'(key_b), 4'b0001);
        step(4'b0001, 1'b1, 1'b1, 1'b1);
        chk("s4_set_wins", int'(v_b), 1);
        step(4'b0001, 1'b0, 1'b1, 1'b1);
        chk("s4_cleared", int'(v_b), 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b1, 1'b1);

        // Release before acceptance keeps the event; FSM back in idle afterwards.
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("s5_retained", int'(key_a), 4'b0001);
        step(4'b0000, 1'b1, 1'b1, 1'b1);
        chk("s5_accepted", int'(v_a), 0);
        step(4'b0001, 1'b1, 1'b1, 1'b1);
        chk("s5_repress", int'(key_a), 4'b0001);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-hold, then the held key is a fresh press.
        for (int i = 0; i < 6; i++) step(4'b0001, 1'b1, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_v_a", int'(v_a), 0);
        chk("s6_rst_key_a", int'(key_a), 0);
        chk("s6_rst_v_b", int'(v_b), 0);
        mreset();
        #2 rst_n = 1'b1;
        clr_cnt();
        for (int i = 0; i < 11; i++) step(4'b0001, 1'b1, 1'b1, 1'b1);
        chk("s6_after_rst", cnt_a[0], 2);

        // Random holds, sparse ticks and random acceptance.
        kr = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) kr = 4'($urandom);
            step(kr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Consumer end of the debounced key interface. Takes the synchronized, active-high key levels and turns them into discrete one-hot key events with typematic auto-repeat.
- Presents events to the game logic through a valid/yumi handshake.
- Sits between the key debouncer and the Tetris game FSM. The press is the first event, then after a delay, repeats at a fixed rate while the key is held.

Parameters:
- width_p, 4, number of keys.
- repeat_delay_p, 10, ticks from the press event to the first repeat event; legal range >=1.
- repeat_rate_p, 3, ticks between consecutive repeat events; legal range >=1.
- repeat_mask_p, {width_p{1'b1}}, bit k=1 means key k auto-repeats; bit k=0 means one event per press.

Ports:
- clk_i  input  1  system clock.
- reset_n_i  input  1  asynchronous, active-low reset.
- tick_i  input  1  one-cycle sample strobe (25 Hz rate); all key sampling and counting happens only on cycles with tick_i=1.
- keys_i  input  width_p  debounced key levels, 1 = pressed.
- v_o  output  1  an event is pending.
- key_o  output  width_p  one-hot key of the presented event; all zeros when v_o=0.
- yumi_i  input  1  consumer accepts the presented event this cycle.

Behaviour:
- Reset (asynchronous, reset_n_i=0): all per-key FSMs go to IDLE, all counters go to 0, all pending bits go to 0, v_o=0, key_o=0. Asserting reset mid-hold discards any hold and pending state. After release, a key still held counts as a fresh press on the next tick.
- Per key k: FSM states IDLE, DELAY, REPEAT, HELD, plus a counter of width $clog2(max(repeat_delay_p,repeat_rate_p)+1) and a pending bit.
- On cycles with tick_i=0, FSMs and counters hold their values.
- Transitions on tick_i=1:
  - IDLE and keys_i[k]=1: set pending[k]. Next state is DELAY (cnt=0) if repeat_mask_p[k]=1, else HELD.
  - IDLE and keys_i[k]=0: stay in IDLE.
  - DELAY and keys_i[k]=0: go to IDLE, cnt=0.
  - DELAY and keys_i[k]=1 with cnt==repeat_delay_p-1: set pending[k], go to REPEAT, cnt=0.
  - DELAY and keys_i[k]=1 otherwise: cnt++.
  - REPEAT and keys_i[k]=0: go to IDLE, cnt=0.
  - REPEAT and keys_i[k]=1 with cnt==repeat_rate_p-1: set pending[k], cnt=0.
  - REPEAT and keys_i[k]=1 otherwise: cnt++.
  - HELD and keys_i[k]=0: go to IDLE.
  - HELD and keys_i[k]=1: stay in HELD.
- Event timing: press sampled at tick T gives events at T, T+D, T+D+R, T+D+2R, … (D=repeat_delay_p, R=repeat_rate_p) while the key stays held.
- Output:
  - v_o = OR of pending.
  - key_o = one-hot of the lowest-index set pending bit (fixed priority, index 0 highest).
  - Both are decoded from registered state; latency from the pending-setting edge to v_o is 0 cycles.
- Handshake:
  - v_o=1 and yumi_i=1 clears the pending bit shown on key_o at the clock edge.
  - yumi_i with v_o=0 is ignored.
  - v_o and key_o stay stable until accepted, except that a lower-index key becoming pending may preempt the presented key. The preempted key stays pending.
- Coalescing: an event for key k while pending[k] is already 1 is merged; no count is kept and no error is raised.
- Simultaneous set and clear of the same bit in one cycle: set wins and pending stays 1. The old event is consumed and the new one is queued.
- Release before acceptance: the pending event is retained and delivered.
- A press and release between two ticks is invisible; sampling happens only on tick_i.
- Multiple keys held: each key's FSM runs independently; events are delivered in priority order.

Test Plan:
- Reset, then width_p=4, D=10, R=3; hold keys_i=4'b0001 from tick 0, yumi_i tied 1 → exactly one-cycle events with key_o=4'b0001 at ticks 0, 10, 13, 16, 19; release at tick 20 → no further events.
- repeat_mask_p=4'b1011; hold key 2 (rotate) for 30 ticks → exactly one event key_o=4'b0100; release, then press again → one new event.
- Hold keys 1 and 3 together, yumi_i=0 for 5 cycles → v_o=1 and key_o=4'b0010 steady. Pulse yumi_i once → key_o=4'b1000 next cycle; pulse again → v_o=0.
- D=1, R=1, yumi_i=0, hold key 0 for 5 ticks → single pending event, v_o=1 (coalesced). Pulse yumi_i on a tick where a new event is generated → v_o stays 1; a second pulse → v_o=0.
- Press key 0 at tick 0, release at tick 1 with yumi_i=0 → event still presented. Accept → v_o=0. FSM is in IDLE, so a press at tick 3 gives an event at tick 3.
- Hold key 0 through tick 5, assert reset_n_i=0 asynchronously between clock edges → v_o=0 and key_o=0 immediately. Deassert with key still held → press event on the next tick, then the first repeat D ticks later.
